// File: rtl/timer_pkg.sv
// timer_pkg
//   Shared definitions for the timer halt handshake initiator: FSM state
//   encoding and default timeout sizing.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HALTED  = 2'd2,
        RELEASE = 2'd3
    } halt_state_e;

    localparam int TO_W_DEF      = 8;
    localparam int TO_CYCLES_DEF = 16;

endpackage

// File: rtl/timer_halt_to_cnt.sv
// timer_halt_to_cnt
//   Clearable saturating up-counter with a terminal-count flag. Used to bound
//   how long the halt handshake waits for halt_ack to change.
// Ports
//   clk  in   clock
//   rst  in   synchronous reset, active-high
//   clr  in   clear count to zero (wins over en)
//   en   in   count enable
//   tc   out  count has reached LAST
module timer_halt_to_cnt #(
    parameter int W    = 8,
    parameter int LAST = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == W'(LAST));

endmodule

// File: rtl/timer_halt_ctrl.sv
// timer_halt_ctrl
//   Debug-side initiator of the timer halt handshake. Converts one-cycle
//   halt/resume pulses into a level halt_req, tracks halt_ack to report
//   halted status, and optionally flags an unanswered handshake as a sticky
//   error.
// Build option
//   TIMER_HALT_TIMEOUT_EN : when defined, REQ/RELEASE are bounded by a
//   TO_CYCLES timeout that sets halt_err. When undefined, REQ/RELEASE wait
//   indefinitely, halt_err is tied 0 and err_clr is ignored.
// Ports
//   clk         in   clock
//   rst         in   synchronous reset, active-high
//   dbg_mode    in   debug mode active; halting legal only while 1
//   halt_cmd    in   pulse: request timer halt
//   resume_cmd  in   pulse: release halt / abort pending request
//   err_clr     in   pulse: clear halt_err
//   halt_ack    in   acknowledge from timer core
//   halt_req    out  halt request to timer core (state decode)
//   halted      out  timer confirmed halted (state decode)
//   halt_busy   out  handshake in flight (REQ or RELEASE)
//   halt_err    out  sticky handshake timeout
//
// state   | meaning
// IDLE    | no request, timer running
// REQ     | halt_req driven, waiting for halt_ack
// HALTED  | halt_ack seen, timer held
// RELEASE | halt_req dropped, waiting for halt_ack to fall
module timer_halt_ctrl
    import timer_pkg::*;
#(
    parameter int TO_W      = TO_W_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic dbg_mode,
    input  logic halt_cmd,
    input  logic resume_cmd,
    input  logic err_clr,
    input  logic halt_ack,
    output logic halt_req,
    output logic halted,
    output logic halt_busy,
    output logic halt_err
);

    halt_state_e state_q, state_d;
    logic        to_hit;
    logic        to_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        to_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt_cmd && dbg_mode && !resume_cmd) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (resume_cmd) begin
                    state_d = RELEASE;
                end else if (!dbg_mode) begin
                    state_d = IDLE;
                end else if (halt_ack) begin
                    state_d = HALTED;
                end else if (to_hit) begin
                    state_d = RELEASE;
                    to_fire = 1'b1;
                end
            end
            HALTED: begin
                if (resume_cmd || !dbg_mode) begin
                    state_d = RELEASE;
                end else if (!halt_ack) begin
                    // timer dropped ack on its own: re-assert and wait again
                    state_d = REQ;
                end
            end
            RELEASE: begin
                if (!halt_ack) begin
                    state_d = IDLE;
                end else if (to_hit) begin
                    state_d = IDLE;
                    to_fire = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign halt_req  = (state_q == REQ) || (state_q == HALTED);
    assign halted    = (state_q == HALTED);
    assign halt_busy = (state_q == REQ) || (state_q == RELEASE);

`ifdef TIMER_HALT_TIMEOUT_EN
    logic to_clr;
    logic err_q;

    // Any state change restarts the wait window.
    assign to_clr = (state_d != state_q);

    timer_halt_to_cnt #(
        .W    (TO_W),
        .LAST (TO_CYCLES - 1)
    ) u_to_cnt (
        .clk (clk),
        .rst (rst),
        .clr (to_clr),
        .en  (halt_busy),
        .tc  (to_hit)
    );

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (to_fire) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign halt_err = err_q;
`else
    logic unused_cfg;

    assign to_hit     = 1'b0;
    assign halt_err   = 1'b0;
    assign unused_cfg = ^{err_clr, to_fire, TO_W'(TO_CYCLES - 1)};
`endif

endmodule

// File: tb/tb_timer_halt_ctrl.sv
module tb_timer_halt_ctrl;

    localparam int TO_CYC = 16;
`ifdef TIMER_HALT_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_mode = 1'b0;
    logic halt_cmd = 1'b0;
    logic resume_cmd = 1'b0;
    logic err_clr = 1'b0;
    logic halt_ack = 1'b0;
    logic halt_req, halted, halt_busy, halt_err;
    logic ack_hold0 = 1'b0;

    timer_halt_ctrl #(.TO_W(8), .TO_CYCLES(TO_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .dbg_mode   (dbg_mode),
        .halt_cmd   (halt_cmd),
        .resume_cmd (resume_cmd),
        .err_clr    (err_clr),
        .halt_ack   (halt_ack),
        .halt_req   (halt_req),
        .halted     (halted),
        .halt_busy  (halt_busy),
        .halt_err   (halt_err)
    );

    always #5 clk = ~clk;

    // Reference timer core: acknowledges one cycle after dbg_mode & halt_req.
    always @(posedge clk) halt_ack <= ack_hold0 ? 1'b0 : (dbg_mode & halt_req);

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_ASK, M_HELD, M_DROP} mph_t;
    typedef struct {
        logic req;
        logic hlt;
        logic busy;
        logic err;
    } exp_t;

    mph_t m_ph = M_IDLE;
    int   m_cyc = 0;
    int   m_entry = 0;
    bit   m_err = 1'b0;
    exp_t sb_q[$];

    int total = 0;
    int bad = 0;
    int mon_cyc = 0;

    task automatic model_step(input logic r, d, hc, rc, ec, ack);
        mph_t nxt;
        bit   expired, set_err;
        nxt     = m_ph;
        set_err = 1'b0;
        expired = TO_ON && ((m_cyc - m_entry) >= TO_CYC - 1);
        if (r) begin
            nxt   = M_IDLE;
            m_err = 1'b0;
        end else begin
            case (m_ph)
                M_IDLE: if (hc && d && !rc) nxt = M_ASK;
                M_ASK: begin
                    if (rc) nxt = M_DROP;
                    else if (!d) nxt = M_IDLE;
                    else if (ack) nxt = M_HELD;
                    else if (expired) begin nxt = M_DROP; set_err = 1'b1; end
                end
                M_HELD: begin
                    if (rc || !d) nxt = M_DROP;
                    else if (!ack) nxt = M_ASK;
                end
                M_DROP: begin
                    if (!ack) nxt = M_IDLE;
                    else if (expired) begin nxt = M_IDLE; set_err = 1'b1; end
                end
                default: nxt = M_IDLE;
            endcase
            if (set_err) m_err = 1'b1;
            else if (ec && TO_ON) m_err = 1'b0;
        end
        if (r || nxt != m_ph) m_entry = m_cyc + 1;
        m_ph  = nxt;
        m_cyc = m_cyc + 1;
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cycle(input logic r, d, hc, rc, ec, h0);
        exp_t e;
        @(negedge clk);
        rst        = r;
        dbg_mode   = d;
        halt_cmd   = hc;
        resume_cmd = rc;
        err_clr    = ec;
        ack_hold0  = h0;
        model_step(r, d, hc, rc, ec, halt_ack);
        e.req  = (m_ph == M_ASK) || (m_ph == M_HELD);
        e.hlt  = (m_ph == M_HELD);
        e.busy = (m_ph == M_ASK) || (m_ph == M_DROP);
        e.err  = m_err;
        sb_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n, input logic d, input logic h0);
        repeat (n) cycle(1'b0, d, 1'b0, 1'b0, 1'b0, h0);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, mon_cyc, act, want);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        mon_cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("halt_req", halt_req, e.req);
            chk("halted", halted, e.hlt);
            chk("halt_busy", halt_busy, e.busy);
            chk("halt_err", halt_err, e.err);
        end
    end

    // ---------------- stimulus ----------------
    logic d_r  = 1'b1;
    logic h0_r = 1'b0;

    initial begin
        // reset
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b1, 1'b0);

        // 1: basic halt / resume latency
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(9, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(5, 1'b1, 1'b0);

        // 2: halt without debug mode is ignored
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(5, 1'b0, 1'b0);

        // 3: ack held low -> timeout, err_clr; second run with set/clear collision
        idle_cycles(2, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycles(20, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycles(3, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_cycles(3, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycles(TO_CYC - 1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycles(3, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_cycles(3, 1'b1, 1'b0);

        // 4: simultaneous halt+resume in IDLE and in HALTED
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycles(3, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(4, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycles(4, 1'b1, 1'b0);

        // 5: leave debug mode while halted
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(4, 1'b1, 1'b0);
        idle_cycles(4, 1'b0, 1'b0);

        // 6: reset while halted
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(4, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(4, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) d_r = ~d_r;
            if ($urandom_range(0, 99) == 0) h0_r = ~h0_r;
            cycle($urandom_range(0, 299) == 0, d_r,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 11) == 0, h0_r);
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain left=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
